sqrt_arbiter: RTL and testbench
===============================

SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing one square-root datapath.
REQ-002 Parameter SIG_W, default 8: significand width (1+LAMP_FLOAT_F_DW).
REQ-003 Parameter RES_W, default 16: result width (2*(1+LAMP_FLOAT_F_DW)).
REQ-004 Parameter TIMEOUT, default 64: maximum WAIT cycles before an error response.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid_i  in  N_REQ  per-requester operation request.
REQ-009 req_ready_o  out  N_REQ  one-hot accept strobe.
REQ-010 req_s_i  in  N_REQ*SIG_W  packed significands; requester k occupies bits [k*SIG_W +: SIG_W].
REQ-011 req_odd_i, req_inv_i, req_special_i  in  N_REQ each  odd-exponent, inverse-sqrt and special-case flags.
REQ-012 rsp_valid_o  out  N_REQ  one-hot response valid.
REQ-013 rsp_ready_i  in  N_REQ  per-requester response accept.
REQ-014 rsp_res_o  out  RES_W  result; rsp_err_o  out  1  timeout flag.
REQ-015 sqrt_do_o  out  1  datapath start pulse; sqrt_s_o  out  SIG_W; sqrt_odd_o, sqrt_inv_o, sqrt_special_o  out  1 each.
REQ-016 sqrt_valid_i  in  1  datapath result pulse; sqrt_res_i  in  RES_W  datapath result.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; at most one operation is outstanding at a time.
REQ-019 In IDLE with any req_valid_i set, the block SHALL grant the first valid requester searching upward from (last_grant+1) mod N_REQ, wrapping around.
REQ-020 The grant SHALL be combinational: req_ready_o[g]=1 in that same IDLE cycle, with req_ready_o zero in all other states and for all other requesters.
REQ-021 On the grant edge, the block SHALL register g, the significand and the three flags, clear the timeout counter, and enter ISSUE.
REQ-022 ISSUE SHALL last one cycle, with sqrt_do_o=1 and sqrt_* driven from the registered operands; next state is WAIT.
REQ-023 sqrt_do_o SHALL be 0 in every state except ISSUE; sqrt_* data outputs hold their last registered value.
REQ-024 In WAIT, sqrt_valid_i=1 SHALL latch sqrt_res_i into rsp_res_o, clear rsp_err_o and enter RESP.
REQ-025 In WAIT without sqrt_valid_i, the counter SHALL increment; when the counter equals TIMEOUT-1 the block SHALL enter RESP with rsp_res_o=0 and rsp_err_o=1.
REQ-026 If sqrt_valid_i and the timeout condition occur in the same cycle, the valid result SHALL win (err=0).
REQ-027 sqrt_valid_i asserted in IDLE, ISSUE or RESP SHALL be ignored, with no state change.
REQ-028 In RESP, rsp_valid_o[g]=1 SHALL be held with stable rsp_res_o and rsp_err_o until rsp_ready_i[g]=1; on that edge the block SHALL set last_grant=g and return to IDLE.
REQ-029 rsp_ready_i of non-granted requesters SHALL be ignored.
REQ-030 Latency SHALL be: grant at cycle t, sqrt_do_o at t+1, earliest rsp_valid_o at t+3; there is a mandatory one-cycle IDLE bubble between a response handshake and the next grant.

Reset
REQ-031 With rst=1, the block SHALL return to IDLE and drive req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_* and busy_o to 0, with the counter at 0 and last_grant=N_REQ-1 (requester 0 has first priority).
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no response; the datapath shares the same rst.

Verification
REQ-033 Single request: req_valid_i=01, s=0x80, odd=0, inv=0; datapath returns 0x8000 two cycles after the start pulse -> ready at t, do at t+1, rsp_valid_o=01 with res=0x8000 and err=0 at t+4; deasserts one cycle after rsp_ready_i.
REQ-034 Round-robin: req_valid_i=11 held continuously -> grants alternate 0,1,0,1 after reset, with exactly one grant per operation.
REQ-035 Special case: req_special_i=1 and the datapath pulses valid one cycle after do -> rsp_valid_o at t+3.
REQ-036 Timeout: sqrt_valid_i held 0 with TIMEOUT=64 -> rsp_err_o=1, rsp_res_o=0 on entering RESP after 64 WAIT cycles; with valid arriving in the final WAIT cycle -> err=0.
REQ-037 Backpressure/reset: hold rsp_ready_i=0 for 10 cycles -> response stable and no new grant; assert rst during WAIT -> all outputs 0 next cycle and requester 0 granted first afterwards.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that shares one square-root datapath among N_REQ requesters,
// with one operation in flight, a WAIT-state timeout and held responses.
module sqrt_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned SIG_W   = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*SIG_W-1:0] req_s_i,
  input  logic [N_REQ-1:0]       req_odd_i,
  input  logic [N_REQ-1:0]       req_inv_i,
  input  logic [N_REQ-1:0]       req_special_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  input  logic [N_REQ-1:0]       rsp_ready_i,
  output logic [RES_W-1:0]       rsp_res_o,
  output logic                   rsp_err_o,
  output logic                   sqrt_do_o,
  output logic [SIG_W-1:0]       sqrt_s_o,
  output logic                   sqrt_odd_o,
  output logic                   sqrt_inv_o,
  output logic                   sqrt_special_o,
  input  logic                   sqrt_valid_i,
  input  logic [RES_W-1:0]       sqrt_res_i,
  output logic                   busy_o
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    last_grant, gnt_q, gnt_idx;
  logic             gnt_found;
  logic [CW-1:0]    cnt;
  logic [SIG_W-1:0] s_q;
  logic             odd_q, inv_q, special_q;
  logic [RES_W-1:0] res_q;
  logic             err_q;
  logic             timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Rotating priority: search upward from the requester after the last one served.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(last_grant) + 1 + i) % N_REQ;
      if (!gnt_found && req_valid_i[GW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready_o[gnt_idx] = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (sqrt_valid_i || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o[gnt_q] = 1'b1;
        if (rsp_ready_i[gnt_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      gnt_q      <= '0;
      cnt        <= '0;
      s_q        <= '0;
      odd_q      <= 1'b0;
      inv_q      <= 1'b0;
      special_q  <= 1'b0;
      res_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            gnt_q     <= gnt_idx;
            s_q       <= req_s_i[gnt_idx*SIG_W +: SIG_W];
            odd_q     <= req_odd_i[gnt_idx];
            inv_q     <= req_inv_i[gnt_idx];
            special_q <= req_special_i[gnt_idx];
            cnt       <= '0;
          end
        end
        WAIT: begin
          // A result arriving on the timeout cycle still wins over the error.
          if (sqrt_valid_i) begin
            res_q <= sqrt_res_i;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i[gnt_q]) last_grant <= gnt_q;
        end
        default: ;
      endcase
    end
  end

  assign sqrt_do_o      = (state == ISSUE);
  assign sqrt_s_o       = s_q;
  assign sqrt_odd_o     = odd_q;
  assign sqrt_inv_o     = inv_q;
  assign sqrt_special_o = special_q;
  assign rsp_res_o      = res_q;
  assign rsp_err_o      = err_q;
  assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter: random requesters, a delayed datapath model
// and a monitor that predicts grants, start pulses and responses from cycle timestamps.
module tb_sqrt_arbiter;
  localparam int N  = 2;
  localparam int SW = 8;
  localparam int RW = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i, req_ready_o, req_odd_i, req_inv_i, req_special_i;
  logic [N*SW-1:0] req_s_i;
  logic [N-1:0]    rsp_valid_o, rsp_ready_i;
  logic [RW-1:0]   rsp_res_o, sqrt_res_i;
  logic            rsp_err_o, sqrt_do_o, sqrt_odd_o, sqrt_inv_o, sqrt_special_o;
  logic [SW-1:0]   sqrt_s_o;
  logic            sqrt_valid_i, busy_o;

  always #5 clk = ~clk;

  sqrt_arbiter #(.N_REQ(N), .SIG_W(SW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_s_i(req_s_i),
    .req_odd_i(req_odd_i), .req_inv_i(req_inv_i), .req_special_i(req_special_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_err_o(rsp_err_o),
    .sqrt_do_o(sqrt_do_o), .sqrt_s_o(sqrt_s_o), .sqrt_odd_o(sqrt_odd_o),
    .sqrt_inv_o(sqrt_inv_o), .sqrt_special_o(sqrt_special_o),
    .sqrt_valid_i(sqrt_valid_i), .sqrt_res_i(sqrt_res_i), .busy_o(busy_o)
  );

  typedef struct {
    int          k;
    logic [SW-1:0] s;
    logic        odd, inv, spc;
  } op_t;

  op_t op_q[$];
  int  dly_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  force_dly = -1;
  int  req_mode = 0;   // 0 none, 1 requester 0 with s=0x80, 2 all held, 3 random
  int  rdy_mode = 0;   // 0 always ready, 1 random, 2 held low
  bit  m_busy = 1'b0;
  int  m_last = N - 1;
  int  t_grant = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] dp_f(logic [SW-1:0] s, logic odd, logic inv, logic spc);
    return (RW'(s) << (RW - SW)) ^ RW'({odd, inv, spc});
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Requesters
  initial begin
    logic [N-1:0] rdy_seen;
    req_valid_i = '0; req_s_i = '0; req_odd_i = '0; req_inv_i = '0; req_special_i = '0;
    forever begin
      @(negedge clk);
      rdy_seen = req_ready_o;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (rdy_seen[k] && req_mode != 2) req_valid_i[k] = 1'b0;
        if (req_mode == 0) req_valid_i[k] = 1'b0;
        else if (req_mode == 1) begin
          if (k == 0 && !req_valid_i[0]) begin
            req_valid_i[0] = 1'b1; req_s_i[SW-1:0] = 8'h80;
            req_odd_i[0] = 1'b0; req_inv_i[0] = 1'b0; req_special_i[0] = 1'b0;
          end else if (k != 0) req_valid_i[k] = 1'b0;
        end else if (!req_valid_i[k] || rdy_seen[k]) begin
          if (req_mode == 2 || $urandom_range(0, 2) == 0) begin
            req_valid_i[k]        = 1'b1;
            req_s_i[k*SW +: SW]   = SW'($urandom);
            req_odd_i[k]          = 1'($urandom);
            req_inv_i[k]          = 1'($urandom);
            req_special_i[k]      = ($urandom_range(0, 3) == 0);
          end
        end
      end
    end
  end

  // Response acceptors
  initial begin
    rsp_ready_i = '0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready_i = '1;
        1:       rsp_ready_i = N'($urandom);
        default: rsp_ready_i = '0;
      endcase
    end
  end

  // Datapath model: answers d cycles after the start pulse; d > TO+1 never answers,
  // d == TO+1 lands one cycle late, in the response state.
  initial begin
    int d, r;
    bit ab;
    logic [RW-1:0] res;
    sqrt_valid_i = 1'b0; sqrt_res_i = '0;
    forever begin
      @(negedge clk);
      if (sqrt_do_o && !rst) begin
        if (force_dly >= 0) d = force_dly;
        else begin
          r = $urandom_range(0, 19);
          d = (r == 0) ? TO : (r == 1) ? TO + 1 : (r == 2) ? TO - 1 : (r == 3) ? 300
            : $urandom_range(1, 6);
        end
        res = dp_f(sqrt_s_o, sqrt_odd_o, sqrt_inv_o, sqrt_special_o);
        dly_q.push_back(d);
        if (d <= TO + 1) begin
          ab = 1'b0;
          for (int i = 0; i < d; i++) begin
            if (rst) ab = 1'b1;
            @(posedge clk);
          end
          #1;
          if (!ab && !rst) begin
            sqrt_valid_i = 1'b1; sqrt_res_i = res;
            @(posedge clk); #1;
            sqrt_valid_i = 1'b0; sqrt_res_i = RW'($urandom);
          end
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit rst_prev;
    logic [N-1:0] e;
    int gk, d, rc;
    logic [RW-1:0] r;
    logic err;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_ready", req_ready_o, 0);
        if (rst_prev)
          chk("rst_outputs", {rsp_valid_o, rsp_res_o, rsp_err_o, sqrt_do_o, sqrt_s_o,
                              sqrt_odd_o, sqrt_inv_o, sqrt_special_o, busy_o}, 0);
        m_busy = 1'b0; m_last = N - 1;
        op_q.delete(); dly_q.delete();
        rst_prev = 1'b1;
      end else begin
        rst_prev = 1'b0;
        chk("busy", busy_o, m_busy);
        if (!m_busy) begin
          e = '0; gk = -1;
          for (int i = 1; i <= N; i++) begin
            if (gk < 0 && req_valid_i[(m_last + i) % N]) gk = (m_last + i) % N;
          end
          if (gk >= 0) e[gk] = 1'b1;
          chk("grant", req_ready_o, e);
          if (gk >= 0) begin
            op_q.push_back('{gk, req_s_i[gk*SW +: SW], req_odd_i[gk], req_inv_i[gk],
                             req_special_i[gk]});
            m_busy = 1'b1; t_grant = cyc;
          end
        end else chk("ready_while_busy", req_ready_o, 0);
        chk("sqrt_do", sqrt_do_o, m_busy && cyc == t_grant + 1);
        if (sqrt_do_o && op_q.size() > 0)
          chk("sqrt_operands", {sqrt_s_o, sqrt_odd_o, sqrt_inv_o, sqrt_special_o},
              {op_q[0].s, op_q[0].odd, op_q[0].inv, op_q[0].spc});
        if (m_busy && cyc > t_grant) begin
          e = '0; r = '0; err = 1'b0;
          if (dly_q.size() > 0 && op_q.size() > 0) begin
            d = dly_q[0];
            if (d <= TO) begin
              rc = t_grant + 1 + d + 1;
              r  = dp_f(op_q[0].s, op_q[0].odd, op_q[0].inv, op_q[0].spc);
            end else begin
              rc = t_grant + 1 + TO + 1;
              err = 1'b1;
            end
            if (cyc >= rc) e[op_q[0].k] = 1'b1;
          end
          chk("rsp_valid", rsp_valid_o, e);
          if (e != 0) begin
            chk("rsp_data", {rsp_res_o, rsp_err_o}, {r, err});
            if (rsp_ready_i[op_q[0].k]) begin
              m_last = op_q[0].k;
              void'(op_q.pop_front()); void'(dly_q.pop_front());
              m_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    req_mode = 0; rdy_mode = 0;
    n = 0;
    while ((m_busy || req_valid_i != 0) && n < 400) begin
      @(posedge clk); n++;
    end
    chk("drain", m_busy, 0);
  endtask

  task automatic one_op(int d);
    force_dly = d; req_mode = 1;
    repeat (2) @(posedge clk);
    drain();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    one_op(2);
    force_dly = 1; req_mode = 3; repeat (20) @(posedge clk); drain();
    force_dly = 3; req_mode = 2; repeat (40) @(posedge clk); drain();
    one_op(300);
    one_op(TO);
    one_op(TO - 1);
    one_op(TO + 1);
    force_dly = 2; req_mode = 2; rdy_mode = 2;
    repeat (15) @(posedge clk);
    drain();
    force_dly = 300; req_mode = 2;
    n = 0;
    while (!(m_busy && cyc > t_grant + 3) && n < 50) begin
      @(posedge clk); n++;
    end
    chk("reach_wait", m_busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    force_dly = 2;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    drain();
    force_dly = -1; req_mode = 3; rdy_mode = 1;
    repeat (1500) @(posedge clk);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", fails);
    $fatal(1);
  end

endmodule
